snake_game_controller_gen2: RTL and testbench
=============================================

Name: snake_game_controller_gen2

Overview:
Parametrised second-generation game controller for the snake game. It adds multiple lives with a respawn state, level progression with a saturating speed ramp, and a buffered direction queue so quick successive turns are not lost. It sits between the input handler and the snake data manager, food generator, score display and sound unit, and replaces the single-life, fixed-step controller.

Parameters:
SCORE_W, 16, score counter width
SND_W, 3, sound event code width (min 3)
TICK_W, 26, tick period counter width
INITIAL_PERIOD, 50_000_000, clk cycles per move at level 0
PERIOD_STEP, 5_000_000, period decrease per level-up
MIN_PERIOD, 10_000_000, period floor
FOOD_PER_LEVEL, 4, foods eaten per level-up (>=1)
LIVES, 3, lives per game (1..7)
DIRQ_DEPTH, 2, direction queue depth (1..8)

Ports:
clk  in  1  system clock
reset_global_n  in  1  asynchronous active-low reset
soft_reset_in  in  1  synchronous high reset pulse; same effect as reset
dir_in  in  2  requested direction, 00 up / 01 down / 10 left / 11 right
dir_valid_in  in  1  dir_in qualifier, one request per high cycle
start_pause_in  in  1  start/pause button level, rising-edge detected
food_eaten_in  in  1  food-eaten level, rising-edge detected
collision_in  in  1  collision level, rising-edge detected
state_out  out  3  0 IDLE, 1 PLAYING, 2 PAUSED, 3 RESPAWN, 4 GAME_OVER
dir_out  out  2  direction applied to the current move
move_cmd_out  out  1  one-cycle move pulse
grow_cmd_out  out  1  one-cycle grow pulse
gen_food_cmd_out  out  1  one-cycle food-generate pulse
reset_dm_cmd_out  out  1  one-cycle snake data manager reinit pulse
score_out  out  SCORE_W  score
level_out  out  8  current level
lives_out  out  3  remaining lives
sound_code_out  out  SND_W  1 eat, 2 game over, 3 start, 4 level up, 5 life lost
sound_trigger_out  out  1  one-cycle sound pulse, qualifies sound_code_out

Behaviour:
- Reset, either reset_global_n low (asynchronous) or soft_reset_in high (synchronous), applies these values:
  - state IDLE; dir_out 00; all pulse outputs 0; score 0; level 0; lives_out LIVES; sound_code 0.
  - Period INITIAL_PERIOD; tick counter 0; direction queue empty; edge-detect history 0.
- Edge detection: registered, giving event = in & ~prev.
- All outputs are registered. An input rising at cycle n produces its output pulse at cycle n+2.
- Tick counter runs only in PLAYING:
  - Counts 0..period-1 and raises an internal tick at wrap.
  - Holds its value in PAUSED.
  - Clears to 0 in IDLE, RESPAWN and GAME_OVER.
- Direction queue:
  - A request is enqueued only in PLAYING, and only if it is neither equal nor opposite to the reference direction. The reference direction is the last queued entry, or dir_out if the queue is empty.
  - A request arriving while the queue is full is dropped.
  - On each tick the head is popped into dir_out in the same registered update that asserts move_cmd_out. If the queue is empty, dir_out is unchanged.
  - The queue clears on entry to IDLE and RESPAWN.
- IDLE: start edge goes to PLAYING. It pulses reset_dm_cmd and gen_food, sets sound 3, clears score/level, sets lives to LIVES, sets dir_out to 00 and sets period to INITIAL_PERIOD.
- PLAYING, with events evaluated in this priority order:
  1. Collision edge: if lives_out > 1, decrement lives, go to RESPAWN, sound 5. Otherwise set lives to 0, go to GAME_OVER, sound 2. A food edge in the same cycle is ignored.
  2. Start edge: go to PAUSED.
  3. Food edge: grow + gen_food pulses, and score+1 (saturates at all-ones).
     - Food count increments. When it reaches FOOD_PER_LEVEL it clears, level+1 (saturates at 255), period = max(period - PERIOD_STEP, MIN_PERIOD), and sound 4. Otherwise sound 1.
     - Period arithmetic is done in TICK_W+1 bits to avoid underflow.
  - Tick handling is independent of items 2 and 3 and still issues move_cmd in the same cycle. A tick coincident with a collision is suppressed.
- PAUSED: start edge returns to PLAYING. The counter resumes from its held value.
- RESPAWN:
  - The entry cycle pulses reset_dm_cmd and gen_food and sets dir_out to 00.
  - Start edge goes to PLAYING.
  - Score, level and period are retained.
- GAME_OVER: start edge goes to IDLE. Outputs hold their values until then.
- At most one sound per cycle, with priority 2 > 5 > 3 > 4 > 1.
- Illegal state encodings return to IDLE on the next cycle.
- Reset asserted mid-game: immediate return to reset values. No pending pulses survive.

Test Plan:
- Reset, then start_pause rises at cycle 10 -> at cycle 12: state 1, reset_dm/gen_food/sound_trigger high 1 cycle, sound_code 3, lives_out 3.
- Test parameters INITIAL_PERIOD=8, PERIOD_STEP=2, MIN_PERIOD=4, FOOD_PER_LEVEL=2; 5 food edges -> score 5, level 2, tick spacing goes 8 then 6 then 4 (held at 4), sound codes 1,4,1,4,1.
- With dir_out 00, requests left then down within one tick period -> next two ticks give dir_out 10 then 01; a request for down with dir_out 00 and an empty queue is dropped; a third request with the queue full (depth 2) is dropped.
- LIVES=2: first collision -> RESPAWN, lives 1, sound 5, reset_dm pulse; start -> PLAYING with score kept; second collision -> GAME_OVER, lives 0, sound 2.
- Collision and food edges in the same cycle -> no grow, score unchanged, sound 2 or 5 only; pause at counter 5 -> resuming completes the period 3 cycles later (period 8).
- reset_global_n low mid-PLAYING, asynchronously between clock edges -> all outputs at reset values immediately; soft_reset_in pulse -> same values at the next clock edge.

Source files
------------

// File: rtl/snake_game_controller_gen2.sv
// Snake game controller: lives with respawn, level-based speed ramp and a
// buffered direction queue between the input handler and the game datapath.
module snake_game_controller_gen2 #(
  parameter int SCORE_W        = 16,
  parameter int SND_W          = 3,
  parameter int TICK_W         = 26,
  parameter int INITIAL_PERIOD = 50_000_000,
  parameter int PERIOD_STEP    = 5_000_000,
  parameter int MIN_PERIOD     = 10_000_000,
  parameter int FOOD_PER_LEVEL = 4,
  parameter int LIVES          = 3,
  parameter int DIRQ_DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset_global_n,
  input  logic               soft_reset_in,
  input  logic [1:0]         dir_in,
  input  logic               dir_valid_in,
  input  logic               start_pause_in,
  input  logic               food_eaten_in,
  input  logic               collision_in,
  output logic [2:0]         state_out,
  output logic [1:0]         dir_out,
  output logic               move_cmd_out,
  output logic               grow_cmd_out,
  output logic               gen_food_cmd_out,
  output logic               reset_dm_cmd_out,
  output logic [SCORE_W-1:0] score_out,
  output logic [7:0]         level_out,
  output logic [2:0]         lives_out,
  output logic [SND_W-1:0]   sound_code_out,
  output logic               sound_trigger_out
);

  localparam int QCW = $clog2(DIRQ_DEPTH + 1);
  localparam int FCW = $clog2(FOOD_PER_LEVEL + 1);
  localparam logic [TICK_W:0]    STEP_X = (TICK_W+1)'(PERIOD_STEP);
  localparam logic [TICK_W-1:0]  MIN_P  = TICK_W'(MIN_PERIOD);
  localparam logic [SND_W-1:0]   SND_EAT   = SND_W'(1);
  localparam logic [SND_W-1:0]   SND_OVER  = SND_W'(2);
  localparam logic [SND_W-1:0]   SND_START = SND_W'(3);
  localparam logic [SND_W-1:0]   SND_LEVEL = SND_W'(4);
  localparam logic [SND_W-1:0]   SND_LIFE  = SND_W'(5);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_PAUSED    = 3'd2,
    S_RESPAWN   = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  // Every register of the block lives in one struct so both resets share one value.
  typedef struct packed {
    state_e                       state;
    logic [1:0]                   dir;
    logic                         move;
    logic                         grow;
    logic                         gen_food;
    logic                         reset_dm;
    logic [SCORE_W-1:0]           score;
    logic [7:0]                   level;
    logic [2:0]                   lives;
    logic [SND_W-1:0]             snd_code;
    logic                         snd_trig;
    logic [TICK_W-1:0]            period;
    logic [TICK_W-1:0]            cnt;
    logic [DIRQ_DEPTH-1:0][1:0]   dq;
    logic [QCW-1:0]               dq_cnt;
    logic [FCW-1:0]               food_cnt;
    logic [2:0]                   prev;   // {collision, food, start}
    logic [2:0]                   ev;
  } ctrl_t;

  function automatic ctrl_t ctrl_reset();
    ctrl_t r;
    r        = '0;
    r.state  = S_IDLE;
    r.lives  = 3'(LIVES);
    r.period = TICK_W'(INITIAL_PERIOD);
    return r;
  endfunction

  ctrl_t ctrl_q, ctrl_d;

  logic                       tick, wrap, push_ok;
  logic [1:0]                 ref_dir;
  logic [QCW-1:0]             qcnt_n;
  logic [DIRQ_DEPTH-1:0][1:0] dq_n;
  logic [FCW-1:0]             food_n;
  logic [TICK_W:0]            per_dec;

  // NOTE: every pulse and scratch variable gets a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl_d          = ctrl_q;
    ctrl_d.move     = 1'b0;
    ctrl_d.grow     = 1'b0;
    ctrl_d.gen_food = 1'b0;
    ctrl_d.reset_dm = 1'b0;
    ctrl_d.snd_trig = 1'b0;
    ctrl_d.prev     = {collision_in, food_eaten_in, start_pause_in};
    ctrl_d.ev       = {collision_in, food_eaten_in, start_pause_in} & ~ctrl_q.prev;
    tick    = 1'b0;
    wrap    = 1'b0;
    push_ok = 1'b0;
    ref_dir = ctrl_q.dir;
    qcnt_n  = ctrl_q.dq_cnt;
    dq_n    = ctrl_q.dq;
    food_n  = ctrl_q.food_cnt + FCW'(1);
    per_dec = {1'b0, ctrl_q.period} - STEP_X;

    case (ctrl_q.state)
      S_IDLE: begin
        ctrl_d.cnt = '0;
        if (ctrl_q.ev[0]) begin
          ctrl_d.state    = S_PLAYING;
          ctrl_d.reset_dm = 1'b1;
          ctrl_d.gen_food = 1'b1;
          ctrl_d.snd_code = SND_START;
          ctrl_d.snd_trig = 1'b1;
          ctrl_d.score    = '0;
          ctrl_d.level    = '0;
          ctrl_d.food_cnt = '0;
          ctrl_d.lives    = 3'(LIVES);
          ctrl_d.dir      = 2'b00;
          ctrl_d.period   = TICK_W'(INITIAL_PERIOD);
          ctrl_d.dq_cnt   = '0;
        end
      end

      S_PLAYING: begin
        // >= rather than == so a period shortened mid-count still wraps.
        wrap       = (ctrl_q.cnt >= ctrl_q.period - TICK_W'(1));
        tick       = wrap && !ctrl_q.ev[2];
        ctrl_d.cnt = wrap ? '0 : ctrl_q.cnt + TICK_W'(1);

        if (tick) begin
          ctrl_d.move = 1'b1;
          if (ctrl_q.dq_cnt != '0) begin
            ctrl_d.dir = ctrl_q.dq[0];
            for (int i = 0; i < DIRQ_DEPTH - 1; i++) dq_n[i] = ctrl_q.dq[i+1];
            qcnt_n = ctrl_q.dq_cnt - QCW'(1);
          end
        end

        for (int i = 0; i < DIRQ_DEPTH; i++)
          if (ctrl_q.dq_cnt == QCW'(i + 1)) ref_dir = ctrl_q.dq[i];
        push_ok = dir_valid_in && (ctrl_q.dq_cnt != QCW'(DIRQ_DEPTH)) &&
                  (dir_in != ref_dir) && (dir_in != {ref_dir[1], ~ref_dir[0]});
        if (push_ok) begin
          for (int i = 0; i < DIRQ_DEPTH; i++)
            if (qcnt_n == QCW'(i)) dq_n[i] = dir_in;
          qcnt_n = qcnt_n + QCW'(1);
        end
        ctrl_d.dq     = dq_n;
        ctrl_d.dq_cnt = qcnt_n;

        if (ctrl_q.ev[2]) begin
          ctrl_d.cnt      = '0;
          ctrl_d.dq_cnt   = '0;
          ctrl_d.snd_trig = 1'b1;
          if (ctrl_q.lives > 3'd1) begin
            ctrl_d.lives    = ctrl_q.lives - 3'd1;
            ctrl_d.state    = S_RESPAWN;
            ctrl_d.snd_code = SND_LIFE;
            ctrl_d.reset_dm = 1'b1;
            ctrl_d.gen_food = 1'b1;
            ctrl_d.dir      = 2'b00;
          end else begin
            ctrl_d.lives    = 3'd0;
            ctrl_d.state    = S_GAME_OVER;
            ctrl_d.snd_code = SND_OVER;
          end
        end else if (ctrl_q.ev[0]) begin
          ctrl_d.state = S_PAUSED;
        end else if (ctrl_q.ev[1]) begin
          ctrl_d.grow     = 1'b1;
          ctrl_d.gen_food = 1'b1;
          ctrl_d.snd_trig = 1'b1;
          if (ctrl_q.score != '1) ctrl_d.score = ctrl_q.score + SCORE_W'(1);
          if (food_n == FCW'(FOOD_PER_LEVEL)) begin
            ctrl_d.food_cnt = '0;
            if (ctrl_q.level != 8'hFF) ctrl_d.level = ctrl_q.level + 8'd1;
            ctrl_d.period   = (per_dec[TICK_W] || per_dec < {1'b0, MIN_P}) ?
                              MIN_P : per_dec[TICK_W-1:0];
            ctrl_d.snd_code = SND_LEVEL;
          end else begin
            ctrl_d.food_cnt = food_n;
            ctrl_d.snd_code = SND_EAT;
          end
        end
      end

      S_PAUSED: begin
        if (ctrl_q.ev[0]) ctrl_d.state = S_PLAYING;
      end

      S_RESPAWN: begin
        ctrl_d.cnt = '0;
        if (ctrl_q.ev[0]) ctrl_d.state = S_PLAYING;
      end

      S_GAME_OVER: begin
        ctrl_d.cnt = '0;
        if (ctrl_q.ev[0]) begin
          ctrl_d.state  = S_IDLE;
          ctrl_d.dq_cnt = '0;
        end
      end

      default: begin
        ctrl_d.state  = S_IDLE;
        ctrl_d.cnt    = '0;
        ctrl_d.dq_cnt = '0;
      end
    endcase

    if (soft_reset_in) ctrl_d = ctrl_reset();
  end

  // NOTE: state updates use non-blocking assignment so every flop samples the
  // pre-edge values; the asynchronous reset branch takes effect without a clock.
  always_ff @(posedge clk or negedge reset_global_n) begin
    if (!reset_global_n) ctrl_q <= ctrl_reset();
    else                 ctrl_q <= ctrl_d;
  end

  assign state_out         = ctrl_q.state;
  assign dir_out           = ctrl_q.dir;
  assign move_cmd_out      = ctrl_q.move;
  assign grow_cmd_out      = ctrl_q.grow;
  assign gen_food_cmd_out  = ctrl_q.gen_food;
  assign reset_dm_cmd_out  = ctrl_q.reset_dm;
  assign score_out         = ctrl_q.score;
  assign level_out         = ctrl_q.level;
  assign lives_out         = ctrl_q.lives;
  assign sound_code_out    = ctrl_q.snd_code;
  assign sound_trigger_out = ctrl_q.snd_trig;

endmodule

// File: tb/tb_snake_game_controller_gen2.sv
// Directed bench for snake_game_controller_gen2 with a short-period build
// so level ramps, pauses and direction buffering are visible in few cycles.
module tb_snake_game_controller_gen2;

  logic        clk = 1'b0;
  logic        reset_global_n = 1'b0;
  logic        soft_reset_in = 1'b0;
  logic [1:0]  dir_in = 2'b00;
  logic        dir_valid_in = 1'b0;
  logic        start_pause_in = 1'b0;
  logic        food_eaten_in = 1'b0;
  logic        collision_in = 1'b0;
  logic [2:0]  state_out;
  logic [1:0]  dir_out;
  logic        move_cmd_out, grow_cmd_out, gen_food_cmd_out, reset_dm_cmd_out;
  logic [15:0] score_out;
  logic [7:0]  level_out;
  logic [2:0]  lives_out;
  logic [2:0]  sound_code_out;
  logic        sound_trigger_out;

  int total = 0;
  int bad   = 0;
  int n;
  int moves;

  snake_game_controller_gen2 #(
    .SCORE_W(16), .SND_W(3), .TICK_W(8),
    .INITIAL_PERIOD(8), .PERIOD_STEP(2), .MIN_PERIOD(4),
    .FOOD_PER_LEVEL(2), .LIVES(3), .DIRQ_DEPTH(2)
  ) dut (
    .clk(clk), .reset_global_n(reset_global_n), .soft_reset_in(soft_reset_in),
    .dir_in(dir_in), .dir_valid_in(dir_valid_in), .start_pause_in(start_pause_in),
    .food_eaten_in(food_eaten_in), .collision_in(collision_in),
    .state_out(state_out), .dir_out(dir_out), .move_cmd_out(move_cmd_out),
    .grow_cmd_out(grow_cmd_out), .gen_food_cmd_out(gen_food_cmd_out),
    .reset_dm_cmd_out(reset_dm_cmd_out), .score_out(score_out),
    .level_out(level_out), .lives_out(lives_out),
    .sound_code_out(sound_code_out), .sound_trigger_out(sound_trigger_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Raise the selected level inputs {collision, food, start} for one cycle and
  // return once the resulting registered outputs are visible.
  task automatic pulse(input logic [2:0] m);
    {collision_in, food_eaten_in, start_pause_in} = m;
    step();
    {collision_in, food_eaten_in, start_pause_in} = 3'b000;
    step();
  endtask

  task automatic wait_move(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!move_cmd_out && cycles < 100);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state_out, 0);
    check({tag, "_score"}, score_out, 0);
    check({tag, "_level"}, level_out, 0);
    check({tag, "_lives"}, lives_out, 3);
    check({tag, "_snd"},   sound_code_out, 0);
    check({tag, "_dir"},   dir_out, 0);
    check({tag, "_pulses"}, {move_cmd_out, grow_cmd_out, gen_food_cmd_out,
                             reset_dm_cmd_out, sound_trigger_out}, 0);
  endtask

  localparam logic [2:0] FOOD_SND [6] = '{1, 4, 1, 4, 1, 4};
  localparam int         FOOD_LVL [6] = '{0, 1, 1, 2, 2, 3};
  localparam int         FOOD_GAP [6] = '{0, 6, 0, 4, 0, 4};

  initial begin
    repeat (3) step();
    check_reset_vals("rst");
    reset_global_n = 1'b1;
    repeat (6) step();

    pulse(3'b001);
    check("start_state", state_out, 1);
    check("start_pulses", {reset_dm_cmd_out, gen_food_cmd_out, sound_trigger_out}, 3'b111);
    check("start_snd", sound_code_out, 3);
    check("start_lives", lives_out, 3);
    step();
    check("start_pulse_len", {reset_dm_cmd_out, gen_food_cmd_out, sound_trigger_out}, 0);

    // First tick lands 8 cycles after PLAYING begins (one already elapsed).
    wait_move(n);
    check("first_tick_gap", n, 7);
    wait_move(n);
    check("tick_gap_8", n, 8);

    // Queue left then down, third request (right) finds the queue full.
    dir_valid_in = 1'b1; dir_in = 2'b10; step();
    dir_in = 2'b01; step();
    dir_in = 2'b11; step();
    dir_valid_in = 1'b0;
    wait_move(n);
    check("dq_gap", n, 5);
    check("dq_first", dir_out, 2'b10);
    wait_move(n);
    check("dq_second", dir_out, 2'b01);
    wait_move(n);
    check("dq_full_drop", dir_out, 2'b01);

    // Pause with the counter at 5, resume, expect the move 3 cycles later.
    repeat (3) step();
    pulse(3'b001);
    check("pause_state", state_out, 2);
    moves = 0;
    repeat (12) begin step(); moves += int'(move_cmd_out); end
    check("pause_no_move", moves, 0);
    pulse(3'b001);
    check("resume_state", state_out, 1);
    wait_move(n);
    check("resume_gap", n, 3);

    for (int i = 0; i < 6; i++) begin
      pulse(3'b010);
      check($sformatf("food%0d_grow", i), {grow_cmd_out, gen_food_cmd_out, sound_trigger_out}, 3'b111);
      check($sformatf("food%0d_snd", i), sound_code_out, FOOD_SND[i]);
      check($sformatf("food%0d_score", i), score_out, i + 1);
      check($sformatf("food%0d_level", i), level_out, FOOD_LVL[i]);
      if (FOOD_GAP[i] != 0) begin
        wait_move(n);
        wait_move(n);
        check($sformatf("food%0d_gap", i), n, FOOD_GAP[i]);
      end
    end

    // Collision and food together: the collision wins.
    pulse(3'b110);
    check("cf_state", state_out, 3);
    check("cf_lives", lives_out, 2);
    check("cf_snd", {sound_trigger_out, sound_code_out}, {1'b1, 3'd5});
    check("cf_grow", grow_cmd_out, 0);
    check("cf_score", score_out, 6);
    check("cf_reset_dm", {reset_dm_cmd_out, gen_food_cmd_out}, 2'b11);
    check("cf_dir", dir_out, 0);
    moves = 0;
    repeat (12) begin step(); moves += int'(move_cmd_out); end
    check("respawn_no_move", moves, 0);
    check("respawn_reset_dm_len", reset_dm_cmd_out, 0);

    pulse(3'b001);
    check("respawn_play", state_out, 1);
    check("respawn_score", score_out, 6);
    check("respawn_level", level_out, 3);

    // Down is opposite to up with an empty queue: dropped.
    dir_valid_in = 1'b1; dir_in = 2'b01; step();
    dir_valid_in = 1'b0;
    wait_move(n);
    check("opp_drop", dir_out, 2'b00);

    pulse(3'b100);
    check("coll2_state", state_out, 3);
    check("coll2_lives", lives_out, 1);
    pulse(3'b001);
    pulse(3'b100);
    check("over_state", state_out, 4);
    check("over_lives", lives_out, 0);
    check("over_snd", {sound_trigger_out, sound_code_out}, {1'b1, 3'd2});
    repeat (5) step();
    check("over_hold", {state_out, score_out}, {3'd4, 16'd6});
    pulse(3'b001);
    check("over_to_idle", state_out, 0);
    pulse(3'b001);
    check("new_game", {state_out, score_out, level_out, lives_out}, {3'd1, 16'd0, 8'd0, 3'd3});

    // Asynchronous reset between clock edges.
    pulse(3'b010);
    check("pre_rst_score", score_out, 1);
    @(posedge clk); #3;
    reset_global_n = 1'b0;
    #1;
    check_reset_vals("async");
    #3 reset_global_n = 1'b1;
    repeat (2) step();

    pulse(3'b001);
    pulse(3'b010);
    check("pre_soft_score", score_out, 1);
    soft_reset_in = 1'b1;
    #2;
    check("soft_not_async", state_out, 1);
    step();
    soft_reset_in = 1'b0;
    check_reset_vals("soft");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
